// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the TopCPU sequencer.
//   state_t        sequencer FSM states
//   OP_*           instruction opcode values (ir[31:28])
//   ALU_*          decoder ALUop values
//   *_HI / *_LO    instruction field bit positions
//   is_halt()      true when an instruction word carries the HALT opcode
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_NOOP = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 13;
  localparam int IMM_HI = 12;
  localparam int IMM_LO = 0;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPC_HI:OPC_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_seq_timeout.sv
// cpu_seq_timeout: fetch-ack watchdog for the sequencer.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   run      high on every FETCH cycle that has no imem_ack
//   expired  high on the TIMEOUT_CYC-th consecutive waiting cycle
// The down-counter reloads whenever run is low, so an ack or leaving FETCH
// restarts the full window.
module cpu_seq_timeout #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the TopCPU datapath.
// Fetches instructions over a req/ack handshake, holds them in ir for the
// decoder, and strobes operand read, ALU latch and register writeback.
// Owns pc, halt detection and the retired-instruction counter.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               pulse; from IDLE/HALT begin fetching at pc 0
//   imem_req/addr/ack/rdata  instruction memory handshake
//   ir                  instruction register (decoder input)
//   alu_op, rd_idx      decoder outputs used to qualify rf_we
//   rf_re, alu_en, rf_we  one-cycle datapath strobes
//   pc, busy, halted, retired, fault   status
// Optional build macro CPU_SEQ_FETCH_TIMEOUT_EN: a missing fetch ack for
// TIMEOUT_CYC cycles sets the sticky fault flag and halts. Without it FETCH
// waits indefinitely and fault is tied low.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | after reset, waiting for start
// FETCH     | imem_req high, waiting for imem_ack
// DECODE    | ir valid; HALT opcode halts, else rf_re
// EXECUTE   | alu_en strobe
// WRITEBACK | rf_we (if useful), pc and retired advance
// HALT      | halted, pc/retired frozen, waiting for start
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic [2:0]       alu_op,
  input  logic [4:0]       rd_idx,
  output logic             rf_re,
  output logic             alu_en,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  state_t state, state_nxt;
  logic   timeout;
  logic   launch;

  // start is honoured only from the two resting states
  assign launch = start && ((state == ST_IDLE) || (state == ST_HALT));

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
  logic fetch_wait;

  assign fetch_wait = (state == ST_FETCH) && !imem_ack;

  cpu_seq_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (fetch_wait),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (launch) begin
      fault <= 1'b0;
    end else if (timeout) begin
      fault <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign fault              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        pc      <= '0;
        retired <= '0;
      end else if (state == ST_WRITEBACK) begin
        pc <= pc + PC_W'(1);
        if (retired != '1) begin
          retired <= retired + CNT_W'(1);
        end
      end
      if ((state == ST_FETCH) && imem_ack) begin
        ir <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    rf_re     = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = ST_DECODE;
        end else if (timeout) begin
          state_nxt = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (is_halt(ir)) begin
          state_nxt = ST_HALT;
        end else begin
          rf_re     = 1'b1;
          state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        alu_en    = 1'b1;
        state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // writes to r0 and NOOP ALU ops still retire but never write
        rf_we     = (alu_op != ALU_NOOP) && (rd_idx != 5'd0);
        state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized self-checking bench for cpu_sequencer.
// An instruction-level model (program counter, retired count, last fetched
// word) produces the expected outputs for every cycle; a negedge process
// compares them against the DUT. The bench also plays the role of the
// instruction decoder (alu_op / rd_idx from ir).
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 4;
  localparam int TMO   = 15;
  localparam int RET_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      ir;
  logic [2:0]       alu_op;
  logic [4:0]       rd_idx;
  logic             rf_re;
  logic             alu_en;
  logic             rf_we;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic             fault;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .alu_op(alu_op), .rd_idx(rd_idx),
    .rf_re(rf_re), .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .busy(busy),
    .halted(halted), .retired(retired), .fault(fault)
  );

  function automatic logic [2:0] dec_alu(input logic [31:0] w);
    case (w[31:28])
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      default:         return ALU_NOOP;
    endcase
  endfunction

  assign alu_op = dec_alu(ir);
  assign rd_idx = ir[27:23];

  function automatic bit exp_we(input logic [31:0] w);
    return (dec_alu(w) != 3'd0) && (w[27:23] != 5'd0);
  endfunction

  typedef struct packed {
    logic             req;
    logic [31:0]      ir;
    logic             re;
    logic             en;
    logic             we;
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] ret;
    logic             fault;
  } obs_t;

  obs_t act_o, exp_o;
  logic [PC_W-1:0] exp_addr;
  bit chk_en = 1'b0;
  int checks = 0;
  int errors = 0;

  int          m_pc, m_ret;
  logic [31:0] m_ir;
  bit          m_fault;

  assign act_o = {imem_req, ir, rf_re, alu_en, rf_we, pc, busy, halted,
                  retired, fault};

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act_o !== exp_o || (exp_o.req && imem_addr !== exp_addr)) begin
        errors++;
        $display("FAIL cycle t=%0t got=%h addr=%h expected=%h addr=%h",
                 $time, act_o, imem_addr, exp_o, exp_addr);
      end
    end
  end

  function automatic obs_t vec(input bit req, input bit re, input bit en,
                               input bit we, input bit bsy, input bit hlt);
    return {req, m_ir, re, en, we, PC_W'(m_pc), bsy, hlt, CNT_W'(m_ret),
            m_fault};
  endfunction

  task automatic pin(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit a, input logic [31:0] d,
                       input bit r);
    start      = s;
    imem_ack   = a;
    imem_rdata = d;
    rst        = r;
  endtask

  task automatic fetch_wait_cycle();
    tick();
    drive(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
    exp_o    = vec(1, 0, 0, 0, 1, 0);
    exp_addr = PC_W'(m_pc);
  endtask

  task automatic noise_cycle(input bit re, input bit en, input bit we);
    tick();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
    exp_o = vec(0, re, en, we, 1, 0);
  endtask

  task automatic run_instr(input logic [31:0] w, input int d);
    for (int k = 0; k < d; k++) fetch_wait_cycle();
    tick();
    drive(1'b0, 1'b1, w, 1'b0);
    exp_o    = vec(1, 0, 0, 0, 1, 0);
    exp_addr = PC_W'(m_pc);
    m_ir = w;
    if (w[31:28] == 4'hF) begin
      noise_cycle(0, 0, 0);
    end else begin
      noise_cycle(1, 0, 0);
      noise_cycle(0, 1, 0);
      noise_cycle(0, 0, exp_we(w));
      m_pc = (m_pc + 1) % (1 << PC_W);
      if (m_ret < RET_MAX) m_ret++;
    end
  endtask

  task automatic rest_cycles(input int n, input bit hlt);
    for (int k = 0; k < n; k++) begin
      tick();
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      exp_o = vec(0, 0, 0, 0, 0, hlt);
    end
  endtask

  task automatic do_start(input bit hlt);
    tick();
    drive(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    exp_o = vec(0, 0, 0, 0, 0, hlt);
    m_pc    = 0;
    m_ret   = 0;
    m_fault = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    m_pc = 0; m_ret = 0; m_ir = '0; m_fault = 1'b0;
    exp_addr = '0;
    tick();
    tick();
    exp_o  = vec(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    pin("reset_pc", pc, 0);
    pin("reset_req", imem_req, 0);
    pin("reset_busy", busy, 0);

    rest_cycles(2, 0);
    do_start(0);

    run_instr(32'h1088_4000, 0);
    pin("add_we", exp_we(32'h1088_4000), 1);
    pin("add_pc", m_pc, 1);
    pin("add_retired", m_ret, 1);

    run_instr(32'h0000_0000, 0);
    pin("noop_we", exp_we(32'h0000_0000), 0);
    pin("noop_retired", m_ret, 2);

    run_instr(32'h3000_0005, 5);
    pin("addi_r0_we", exp_we(32'h3000_0005), 0);
    pin("addi_pc", m_pc, 3);

    run_instr(32'hF000_0000, 0);
    rest_cycles(3, 1);
    pin("halt_pc", m_pc, 3);
    pin("halt_retired", m_ret, 3);
    pin("halt_dut_halted", halted, 1);

    do_start(1);
    for (int i = 0; i < 270; i++) begin
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 14));
      run_instr(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
    pin("wrap_pc", m_pc, 270 % 256);
    pin("sat_retired", m_ret, RET_MAX);

    fetch_wait_cycle();
    tick();
    drive(1'b0, 1'b0, $urandom, 1'b1);
    exp_o = vec(1, 0, 0, 0, 1, 0);
    exp_addr = PC_W'(m_pc);
    m_pc = 0; m_ret = 0; m_ir = '0; m_fault = 1'b0;
    tick();
    drive(1'b0, 1'b1, $urandom, 1'b0);
    exp_o = vec(0, 0, 0, 0, 0, 0);
    tick();
    drive(1'b0, 1'b1, $urandom, 1'b0);
    exp_o = vec(0, 0, 0, 0, 0, 0);
    pin("late_ack_ir", ir, 0);

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
    do_start(0);
    for (int k = 0; k < TMO; k++) begin
      tick();
      drive(1'b0, 1'b0, $urandom, 1'b0);
      exp_o    = vec(1, 0, 0, 0, 1, 0);
      exp_addr = PC_W'(m_pc);
    end
    m_fault = 1'b1;
    tick();
    drive(1'b0, 1'b0, $urandom, 1'b0);
    exp_o = vec(0, 0, 0, 0, 0, 1);
    pin("timeout_fault", fault, 1);
    pin("timeout_req", imem_req, 0);
    rest_cycles(2, 1);
    do_start(1);
    run_instr(32'h2100_0000, 0);
    pin("restart_fault", fault, 0);
`endif

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
